// File: rtl/alu_writeback_if.sv
// ALU result handshake bundle between the 8-bit ALU and its writeback stage.
// The master drives the result and its flags; the slave returns in_ready.
interface alu_writeback_if #(
    parameter int AW = 3,
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] alu_rslt;
    logic          alu_sc_o;
    logic          alu_sc_clr;
    logic          alu_pari;
    logic          alu_pari_clr;
    logic          flag_we;
    logic          wr_en;
    logic [AW-1:0] wr_dst;

    modport master (
        output in_valid, alu_rslt, alu_sc_o, alu_sc_clr,
        output alu_pari, alu_pari_clr, flag_we, wr_en, wr_dst,
        input  in_ready
    );

    modport slave (
        input  in_valid, alu_rslt, alu_sc_o, alu_sc_clr,
        input  alu_pari, alu_pari_clr, flag_we, wr_en, wr_dst,
        output in_ready
    );
endinterface

// File: rtl/alu_writeback.sv
// ALU writeback stage: carry/parity flags, in-order write buffer draining
// to the register file, and youngest-entry bypass to operand fetch.
module alu_writeback #(
    parameter int DEPTH = 2,
    parameter int AW    = 3,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    alu_writeback_if.slave alu,
    output logic          sc_flag,
    output logic          pari_flag,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    input  logic          rf_ready,
    input  logic [AW-1:0] byp_addr,
    output logic          byp_hit,
    output logic [DW-1:0] byp_data
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        buf_q [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          accept;
    logic          push;
    logic          pop;
    logic [PW-1:0] byp_idx;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign accept = alu.in_valid & alu.in_ready;
    assign push   = accept & alu.wr_en;
    assign pop    = rf_we & rf_ready;

    // Occupancy state register; count alone decides empty/full.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    // Occupancy next state: simultaneous push and pop leaves count unchanged.
    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Occupancy outputs; in_ready depends only on registered state.
    always_comb begin
        alu.in_ready = 1'b0;
        rf_we        = 1'b0;
        alu.in_ready = (count < CW'(DEPTH));
        rf_we        = (count != '0);
    end

    // Circular pointers advance on push/pop and wrap at DEPTH.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    // Entry storage; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            buf_q[wr_ptr] <= '{addr: alu.wr_dst, data: alu.alu_rslt};
        end
    end

    // Architectural flags, loaded or cleared by flag-writing results.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sc_flag   <= 1'b0;
            pari_flag <= 1'b0;
        end else if (accept && alu.flag_we) begin
            sc_flag   <= alu.alu_sc_clr ? 1'b0 : alu.alu_sc_o;
            pari_flag <= alu.alu_pari_clr ? 1'b0 : alu.alu_pari;
        end
    end

    assign rf_waddr = buf_q[rd_ptr].addr;
    assign rf_wdata = buf_q[rd_ptr].data;

    // Bypass scan oldest to youngest so the youngest match overrides.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        byp_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            byp_idx = PW'((int'(rd_ptr) + i) % DEPTH);
            if ((CW'(i) < count) && (buf_q[byp_idx].addr == byp_addr)) begin
                byp_hit  = 1'b1;
                byp_data = buf_q[byp_idx].data;
            end
        end
    end
endmodule

// File: tb/tb_alu_writeback.sv
// Directed testbench for alu_writeback (DEPTH=2, AW=3, DW=8).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_alu_writeback;
    logic       clk;
    logic       reset_n;
    logic       sc_flag;
    logic       pari_flag;
    logic       rf_we;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       rf_ready;
    logic [2:0] byp_addr;
    logic       byp_hit;
    logic [7:0] byp_data;

    int total;
    int bad;

    alu_writeback_if #(.AW(3), .DW(8)) alu ();

    alu_writeback #(.DEPTH(2), .AW(3), .DW(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .alu       (alu),
        .sc_flag   (sc_flag),
        .pari_flag (pari_flag),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_ready  (rf_ready),
        .byp_addr  (byp_addr),
        .byp_hit   (byp_hit),
        .byp_data  (byp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [2:0] dst,
                         input logic [7:0] rslt);
        alu.in_valid = v;
        alu.wr_en    = we;
        alu.wr_dst   = dst;
        alu.alu_rslt = rslt;
    endtask

    task automatic flags(input logic fwe, input logic sc, input logic scc,
                         input logic pr, input logic prc);
        alu.flag_we      = fwe;
        alu.alu_sc_o     = sc;
        alu.alu_sc_clr   = scc;
        alu.alu_pari     = pr;
        alu.alu_pari_clr = prc;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset_n  = 1'b0;
        rf_ready = 1'b0;
        byp_addr = 3'd0;
        drive(1'b1, 1'b1, 3'd0, 8'hFF);
        flags(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        // reset with live inputs
        step();
        step();
        #1;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_sc", 32'(sc_flag), 32'd0);
        chk("rst_pari", 32'(pari_flag), 32'd0);
        chk("rst_in_ready", 32'(alu.in_ready), 32'd1);
        chk("rst_byp_hit", 32'(byp_hit), 32'd0);

        // single write, one-cycle latency
        reset_n  = 1'b1;
        rf_ready = 1'b1;
        flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 3'd3, 8'hA5);
        step();
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        #1;
        chk("w1_we", 32'(rf_we), 32'd1);
        chk("w1_addr", 32'(rf_waddr), 32'd3);
        chk("w1_data", 32'(rf_wdata), 32'hA5);
        step();
        chk("w1_drained", 32'(rf_we), 32'd0);

        // backpressure, full, in-order drain
        rf_ready = 1'b0;
        drive(1'b1, 1'b1, 3'd1, 8'h11);
        step();
        chk("bp_ready1", 32'(alu.in_ready), 32'd1);
        chk("bp_head11", 32'(rf_wdata), 32'h11);
        drive(1'b1, 1'b1, 3'd2, 8'h22);
        step();
        chk("bp_full", 32'(alu.in_ready), 32'd0);
        drive(1'b1, 1'b1, 3'd4, 8'h33);
        step();
        chk("bp_still_full", 32'(alu.in_ready), 32'd0);
        chk("bp_head_hold", 32'(rf_wdata), 32'h11);
        chk("bp_addr1", 32'(rf_waddr), 32'd1);
        rf_ready = 1'b1;
        step();
        chk("dr_head22", 32'(rf_wdata), 32'h22);
        chk("dr_ready", 32'(alu.in_ready), 32'd1);
        step();
        chk("pp_head33", 32'(rf_wdata), 32'h33);
        chk("pp_addr4", 32'(rf_waddr), 32'd4);
        chk("pp_count1", 32'(alu.in_ready), 32'd1);
        chk("pp_we", 32'(rf_we), 32'd1);
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        step();
        chk("dr_empty", 32'(rf_we), 32'd0);

        // flags
        rf_ready = 1'b0;
        drive(1'b1, 1'b0, 3'd7, 8'h99);
        flags(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        chk("fl_sc_set", 32'(sc_flag), 32'd1);
        chk("fl_pari_clr", 32'(pari_flag), 32'd0);
        chk("fl_no_wr", 32'(rf_we), 32'd0);
        flags(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk("fl_sc_clr", 32'(sc_flag), 32'd0);
        chk("fl_pari_set", 32'(pari_flag), 32'd1);
        flags(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        chk("fl_hold_sc", 32'(sc_flag), 32'd0);
        chk("fl_hold_pari", 32'(pari_flag), 32'd1);
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        flags(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        chk("fl_noacc_sc", 32'(sc_flag), 32'd0);
        chk("fl_noacc_pari", 32'(pari_flag), 32'd1);
        flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // bypass youngest match
        drive(1'b1, 1'b1, 3'd2, 8'h10);
        step();
        drive(1'b1, 1'b1, 3'd2, 8'h20);
        step();
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        byp_addr = 3'd2;
        #1;
        chk("byp_hit2", 32'(byp_hit), 32'd1);
        chk("byp_young", 32'(byp_data), 32'h20);
        chk("byp_full", 32'(alu.in_ready), 32'd0);
        byp_addr = 3'd5;
        #1;
        chk("byp_miss", 32'(byp_hit), 32'd0);
        chk("byp_miss_dat", 32'(byp_data), 32'h00);

        // reset while full
        reset_n = 1'b0;
        step();
        reset_n  = 1'b1;
        byp_addr = 3'd2;
        #1;
        chk("rf_empty", 32'(rf_we), 32'd0);
        chk("rf_ready", 32'(alu.in_ready), 32'd1);
        chk("rf_pari", 32'(pari_flag), 32'd0);
        chk("rf_byp", 32'(byp_hit), 32'd0);

        // entry popped this cycle still hits
        rf_ready = 1'b1;
        drive(1'b1, 1'b1, 3'd5, 8'h55);
        step();
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        byp_addr = 3'd5;
        #1;
        chk("pop_hit", 32'(byp_hit), 32'd1);
        chk("pop_data", 32'(byp_data), 32'h55);
        chk("pop_we", 32'(rf_we), 32'd1);
        step();
        chk("pop_gone", 32'(byp_hit), 32'd0);
        chk("pop_empty", 32'(rf_we), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
